// File: rtl/pe_port_arbiter.sv
// ============================================================================
// Module   : pe_port_arbiter
// Purpose  : 4:1 round-robin arbiter feeding one HNoC PE input port through a
//            single output register; optional delivery statistics via the
//            HNOC_ARB_STATS_EN macro.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pe_port_arbiter #(
    parameter int DATA_W        = 32,
    parameter int EXPECTED_PKTS = 100
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [4*DATA_W-1:0] i_req_data,
    input  logic [3:0]          i_req_valid,
    output logic [3:0]          o_req_ready,
    output logic [DATA_W-1:0]   o_data,
    output logic                o_data_valid,
    input  logic                i_data_ready,
    output logic [1:0]          o_grant,
    output logic [63:0]         o_pkt_cnt,
    output logic                o_done
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [1:0]          rr_ptr;
    logic [1:0]          winner;
    logic [1:0]          scan_idx;
    logic                any_valid;
    logic                load_en;
    logic                accept;
    logic                out_hs;
    logic [DATA_W-1:0]   data_q;
    logic [1:0]          grant_q;

    // First asserted requester at or after rr_ptr, wrapping mod 4.
    always_comb begin
        winner    = rr_ptr;
        any_valid = 1'b0;
        scan_idx  = rr_ptr;
        for (int i = 0; i < 4; i++) begin
            scan_idx = rr_ptr + 2'(i);
            if (!any_valid && i_req_valid[scan_idx]) begin
                winner    = scan_idx;
                any_valid = 1'b1;
            end
        end
    end

    assign load_en     = (state == EMPTY) || ((state == FULL) && i_data_ready);
    assign accept      = load_en && any_valid && !i_reset;
    assign o_req_ready = accept ? (4'b0001 << winner) : 4'b0000;
    assign out_hs      = o_data_valid && i_data_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A load on the handshake edge keeps the register FULL (no bubble).
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = FULL;
        end else if (out_hs) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_q  <= '0;
            grant_q <= 2'd0;
            rr_ptr  <= 2'd0;
        end else if (accept) begin
            data_q  <= i_req_data[winner*DATA_W +: DATA_W];
            grant_q <= winner;
            rr_ptr  <= winner + 2'd1;
        end
    end

    assign o_data       = data_q;
    assign o_grant      = grant_q;
    assign o_data_valid = (state == FULL);

`ifdef HNOC_ARB_STATS_EN
    logic [15:0] pkt_cnt [4];
    logic [31:0] total_cnt;
    logic        done_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < 4; k++) begin
                pkt_cnt[k] <= 16'd0;
            end
            total_cnt <= 32'd0;
            done_q    <= 1'b0;
        end else if (out_hs) begin
            if (pkt_cnt[grant_q] != 16'hFFFF) begin
                pkt_cnt[grant_q] <= pkt_cnt[grant_q] + 16'd1;
            end
            total_cnt <= total_cnt + 32'd1;
            if ((total_cnt + 32'd1) >= 32'(EXPECTED_PKTS)) begin
                done_q <= 1'b1;
            end
        end
    end

    assign o_pkt_cnt = {pkt_cnt[3], pkt_cnt[2], pkt_cnt[1], pkt_cnt[0]};
    assign o_done    = done_q;
`else
    assign o_pkt_cnt = 64'd0;
    assign o_done    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pe_port_arbiter.sv
// ============================================================================
// Module   : tb_pe_port_arbiter
// Purpose  : Directed self-checking bench for pe_port_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pe_port_arbiter;

    localparam int DATA_W = 32;

    logic                clk;
    logic                reset;
    logic [4*DATA_W-1:0] req_data;
    logic [3:0]          req_valid;
    logic [3:0]          req_ready;
    logic [DATA_W-1:0]   data;
    logic                data_valid;
    logic                data_ready;
    logic [1:0]          grant;
    logic [63:0]         pkt_cnt;
    logic                done;

    int tests;
    int fails;

    pe_port_arbiter #(
        .DATA_W        (DATA_W),
        .EXPECTED_PKTS (8)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req_data   (req_data),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .o_data       (data),
        .o_data_valid (data_valid),
        .i_data_ready (data_ready),
        .o_grant      (grant),
        .o_pkt_cnt    (pkt_cnt),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        req_valid  = 4'hF;
        data_ready = 1'b1;
        req_data   = {32'h11, 32'h22, 32'h33, 32'h44};
        tick();
        tick();
        #1;
        tests++;
        if (data_valid !== 1'b0) begin
            fails++; $display("FAIL reset_valid got=%b exp=0", data_valid);
        end
        tests++;
        if (data !== 32'd0) begin
            fails++; $display("FAIL reset_data got=%h exp=0", data);
        end
        tests++;
        if (grant !== 2'd0) begin
            fails++; $display("FAIL reset_grant got=%0d exp=0", grant);
        end
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
        end
        tests++;
        if (pkt_cnt !== 64'd0 || done !== 1'b0) begin
            fails++; $display("FAIL reset_stats got=%h/%b exp=0/0", pkt_cnt, done);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        reset     = 1'b0;
        req_valid = 4'hF;
        req_data  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++; $display("FAIL rr_ready_first got=%b exp=0001", req_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (data !== 32'hA0 + 32'(k) || data_valid !== 1'b1 || grant !== 2'(k)) begin
                fails++;
                $display("FAIL rr_out%0d got=%h/%b/%0d exp=%h/1/%0d",
                         k, data, data_valid, grant, 32'hA0 + 32'(k), k);
            end
            req_valid[k] = 1'b0;
            exp_rdy = (k < 3) ? (4'b0001 << (k + 1)) : 4'b0000;
            #1;
            tests++;
            if (req_ready !== exp_rdy) begin
                fails++; $display("FAIL rr_ready%0d got=%b exp=%b", k, req_ready, exp_rdy);
            end
        end
        tick();
        tests++;
        if (data_valid !== 1'b0) begin
            fails++; $display("FAIL rr_drain got=%b exp=0", data_valid);
        end
    endtask

    task automatic test_back_to_back();
        req_valid = 4'b0100;
        req_data[2*DATA_W +: DATA_W] = 32'hB0;
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++; $display("FAIL b2b_ready got=%b exp=0100", req_ready);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++;
            if (data !== 32'hB0 + 32'(k) || data_valid !== 1'b1 || grant !== 2'd2) begin
                fails++;
                $display("FAIL b2b_out%0d got=%h/%b/%0d exp=%h/1/2",
                         k, data, data_valid, grant, 32'hB0 + 32'(k));
            end
            if (k < 4) req_data[2*DATA_W +: DATA_W] = 32'hB0 + 32'(k + 1);
            else       req_valid = 4'b0000;
        end
        tick();
        tests++;
        if (data_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_drain got=%b exp=0", data_valid);
        end
    endtask

    task automatic test_stall();
        data_ready = 1'b0;
        req_valid  = 4'b0010;
        req_data[1*DATA_W +: DATA_W] = 32'h55;
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++; $display("FAIL stall_load_ready got=%b exp=0010", req_ready);
        end
        tick();
        req_data[1*DATA_W +: DATA_W] = 32'h66;
        for (int i = 0; i < 10; i++) begin
            #1;
            tests++;
            if (data !== 32'h55 || data_valid !== 1'b1 || grant !== 2'd1 || req_ready !== 4'b0000) begin
                fails++;
                $display("FAIL stall_hold%0d got=%h/%b/%0d/%b exp=55/1/1/0000",
                         i, data, data_valid, grant, req_ready);
            end
            tick();
        end
        req_valid  = 4'b0000;
        data_ready = 1'b1;
        tick();
        tests++;
        if (data_valid !== 1'b0) begin
            fails++; $display("FAIL stall_drain got=%b exp=0", data_valid);
        end
    endtask

    task automatic test_reset_mid();
        data_ready = 1'b0;
        req_valid  = 4'b0001;
        req_data[0 +: DATA_W] = 32'h77;
        tick();
        tests++;
        if (data !== 32'h77 || data_valid !== 1'b1) begin
            fails++; $display("FAIL rmid_load got=%h/%b exp=77/1", data, data_valid);
        end
        req_valid = 4'b1010;
        req_data[1*DATA_W +: DATA_W] = 32'hC1;
        req_data[3*DATA_W +: DATA_W] = 32'hC3;
        reset = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++; $display("FAIL rmid_ready_in_reset got=%b exp=0000", req_ready);
        end
        tick();
        tests++;
        if (data_valid !== 1'b0 || data !== 32'd0 || grant !== 2'd0) begin
            fails++; $display("FAIL rmid_cleared got=%h/%b/%0d exp=0/0/0", data, data_valid, grant);
        end
        reset      = 1'b0;
        data_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++; $display("FAIL rmid_restart_ready got=%b exp=0010", req_ready);
        end
        tick();
        tests++;
        if (data !== 32'hC1 || grant !== 2'd1) begin
            fails++; $display("FAIL rmid_first got=%h/%0d exp=c1/1", data, grant);
        end
        req_valid = 4'b1000;
        tick();
        tests++;
        if (data !== 32'hC3 || grant !== 2'd3) begin
            fails++; $display("FAIL rmid_second got=%h/%0d exp=c3/3", data, grant);
        end
        req_valid = 4'b0000;
        tick();
        tests++;
        if (data_valid !== 1'b0) begin
            fails++; $display("FAIL rmid_drain got=%b exp=0", data_valid);
        end
    endtask

    task automatic test_stats();
        logic [63:0] exp_cnt;
        logic        exp_done;
`ifdef HNOC_ARB_STATS_EN
        exp_cnt  = {16'd2, 16'd2, 16'd2, 16'd2};
        exp_done = 1'b1;
`else
        exp_cnt  = 64'd0;
        exp_done = 1'b0;
`endif
        reset     = 1'b1;
        req_valid = 4'b0000;
        tick();
        reset      = 1'b0;
        data_ready = 1'b1;
        req_data   = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        req_valid  = 4'hF;
        for (int n = 0; n < 8; n++) begin
            tick();
            tests++;
            if (grant !== 2'(n % 4) || data !== 32'hD0 + 32'(n % 4)) begin
                fails++;
                $display("FAIL stats_seq%0d got=%h/%0d exp=%h/%0d",
                         n, data, grant, 32'hD0 + 32'(n % 4), n % 4);
            end
        end
        req_valid = 4'b0000;
        tests++;
        if (done !== 1'b0) begin
            fails++; $display("FAIL stats_done_early got=%b exp=0", done);
        end
        tick();
        tests++;
        if (pkt_cnt !== exp_cnt) begin
            fails++; $display("FAIL stats_cnt got=%h exp=%h", pkt_cnt, exp_cnt);
        end
        tests++;
        if (done !== exp_done) begin
            fails++; $display("FAIL stats_done got=%b exp=%b", done, exp_done);
        end
        tick();
        tests++;
        if (done !== exp_done || data_valid !== 1'b0) begin
            fails++; $display("FAIL stats_sticky got=%b/%b exp=%b/0", done, data_valid, exp_done);
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        reset      = 1'b1;
        req_valid  = 4'b0000;
        req_data   = '0;
        data_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pe_port_arbiter.md
PE_PORT_ARBITER -- requirements
Module: pe_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, flit width in bits.
REQ-002 SHALL have parameter EXPECTED_PKTS, default 100, total output handshakes that set o_done.
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_req_data  input  4*DATA_W  requester k flit in bits [k*DATA_W +: DATA_W].
REQ-006 SHALL have port i_req_valid  input  4  per-requester valid.
REQ-007 SHALL have port o_req_ready  output  4  per-requester ready; at most one bit high.
REQ-008 SHALL have port o_data  output  DATA_W  flit towards the HNoC PE input port.
REQ-009 SHALL have port o_data_valid  output  1  o_data valid.
REQ-010 SHALL have port i_data_ready  input  1  HNoC port ready.
REQ-011 SHALL have port o_grant  output  2  source index of the flit in o_data.
REQ-012 SHALL have port o_pkt_cnt  output  64  per-requester delivered count, 16 bits each, requester k in [k*16 +: 16].
REQ-013 SHALL have port o_done  output  1  sticky: EXPECTED_PKTS flits delivered.

Function
REQ-014 SHALL hold one output register (states EMPTY, FULL) driving o_data, o_data_valid, o_grant.
REQ-015 SHALL define load_en = EMPTY or (FULL and i_data_ready).
REQ-016 SHALL select the winner round-robin among asserted i_req_valid, searching from rr_ptr upward, mod 4.
REQ-017 SHALL assert o_req_ready[winner] combinationally only when load_en and the winner is valid; all other bits 0.
REQ-018 SHALL, on the accept edge, load winner data into the output register, set o_grant=winner, set rr_ptr=(winner+1) mod 4.
REQ-019 SHALL present an accepted flit on o_data/o_data_valid exactly 1 cycle after acceptance.
REQ-020 SHALL sustain 1 flit/cycle when i_data_ready is held high and any requester is valid.
REQ-021 SHALL keep o_data, o_grant, o_data_valid stable while o_data_valid=1 and i_data_ready=0.
REQ-022 SHALL on output handshake with no valid requester go EMPTY (o_data_valid=0 next cycle).
REQ-023 SHALL on output handshake with a valid requester load the next flit in the same edge (back-to-back, no bubble).
REQ-024 SHALL leave rr_ptr unchanged in cycles without an accept.
REQ-025 SHALL tolerate a requester dropping i_req_valid before being granted; no flit is taken from it.
REQ-026 SHALL never duplicate or drop a flit: each requester handshake yields exactly one output handshake.

Reset
REQ-027 SHALL on i_reset=1 at a rising edge: o_data_valid=0, state EMPTY, o_data=0, o_grant=0, rr_ptr=0, o_pkt_cnt=0, o_done=0.
REQ-028 SHALL drive o_req_ready=0 while i_reset=1.
REQ-029 SHALL discard a held flit when reset is asserted mid-operation; it is not counted.

Configuration
REQ-030 SHALL compile delivery statistics only when macro HNOC_ARB_STATS_EN is defined.
REQ-031 SHALL, with HNOC_ARB_STATS_EN, increment o_pkt_cnt[o_grant] on each output handshake, saturating at 16'hFFFF.
REQ-032 SHALL, with HNOC_ARB_STATS_EN, keep a 32-bit total handshake count and set o_done when it reaches EXPECTED_PKTS; o_done stays 1 until reset.
REQ-033 SHALL, without HNOC_ARB_STATS_EN, tie o_pkt_cnt and o_done to 0 with identical port list.

Verification
REQ-034 SHALL cover: reset, then all 4 valid with data 0xA0..0xA3, i_data_ready=1 -> outputs 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, o_grant 0,1,2,3.
REQ-035 SHALL cover: only requester 2 valid for 5 flits, ready high -> 5 back-to-back outputs, o_grant=2, then o_data_valid=0.
REQ-036 SHALL cover: output FULL with 0x55, i_data_ready=0 for 10 cycles -> o_data=0x55 stable, o_req_ready=0 throughout.
REQ-037 SHALL cover: reset asserted while FULL with requesters 1,3 valid -> next cycle o_data_valid=0, grant restarts at requester 1 (rr_ptr=0).
REQ-038 SHALL cover (stats on, EXPECTED_PKTS=8): 2 flits from each requester -> o_pkt_cnt each =2, o_done=1 one cycle after the 8th handshake.
REQ-039 SHALL cover (stats off): same stimulus as REQ-038 -> o_pkt_cnt=0, o_done=0.
